pe_seq_ctrl: RTL

- Initiator-side sequencer for the floating-point MAC processing element (PE).
- Accepts one job as a 2N-word input stream, N = 2**L_RAM_SIZE: B words are written into the PE local RAM, A words into a local buffer.
- Drives the PE one element at a time (serialised by the accumulator feedback), then returns the accumulated dot product on an output stream.
- Sits between the AXI-stream/DMA side and one PE instance.

---
 rtl/pe_seq_pkg.sv | 19 +
 rtl/pe_seq_abuf.sv | 38 +++
 rtl/pe_seq_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_seq_pkg.sv
// Shared state encoding and IEEE-754 constants for the PE sequencer.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_B,
    LOAD_A,
    PREP,
    ISSUE,
    WAIT,
    OUT
  } state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO  = 32'h4000_0000;

endpackage

// File: rtl/pe_seq_abuf.sv
// Port-A operand buffer: N words, one write port, one registered read port.
// The read is requested in PREP so the word is on rdata during ISSUE.
module pe_seq_abuf #(
  parameter int VECTOR_SIZE = 32,
  parameter int L_RAM_SIZE  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [L_RAM_SIZE-1:0]  waddr,
  input  logic [VECTOR_SIZE-1:0] wdata,
  input  logic                   re,
  input  logic [L_RAM_SIZE-1:0]  raddr,
  output logic [VECTOR_SIZE-1:0] rdata
);

  localparam int N = 2**L_RAM_SIZE;

  logic [VECTOR_SIZE-1:0] mem_q [N];
  logic [VECTOR_SIZE-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Initiator-side sequencer for one floating-point MAC PE: load B/A, issue, return sum.
// Optional watchdog on the PE result handshake: define PE_SEQ_TIMEOUT_EN.
module pe_seq_ctrl
  import pe_seq_pkg::*;
#(
  parameter int VECTOR_SIZE    = 32,
  parameter int L_RAM_SIZE     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  output logic                   busy,
  input  logic [VECTOR_SIZE-1:0] s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic                   pe_aresetn,
  output logic [VECTOR_SIZE-1:0] pe_din,
  output logic [L_RAM_SIZE-1:0]  pe_addr,
  output logic                   pe_we,
  output logic [VECTOR_SIZE-1:0] pe_ain,
  output logic                   pe_valid,
  input  logic                   pe_dvalid,
  input  logic [VECTOR_SIZE-1:0] pe_dout,
  output logic [VECTOR_SIZE-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   err
);

  localparam int N     = 2**L_RAM_SIZE;
  localparam int IDX_W = L_RAM_SIZE + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_inc;
  logic                   clr_q, clr_d;
  logic                   busy_q, busy_d;
  logic                   s_tready_q, s_tready_d;
  logic                   pe_we_q, pe_we_d;
  logic                   pe_valid_q, pe_valid_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [L_RAM_SIZE-1:0]  pe_addr_q, pe_addr_d;
  logic [VECTOR_SIZE-1:0] pe_din_q, pe_din_d;
  logic [VECTOR_SIZE-1:0] m_tdata_q, m_tdata_d;
  logic                   beat, abuf_we, abuf_re;

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;
`endif

  assign beat    = s_tvalid & s_tready_q;
  assign idx_inc = idx_q + IDX_W'(1);
  assign abuf_we = beat && (state_q == LOAD_A);
  assign abuf_re = (state_q == PREP);

  pe_seq_abuf #(
    .VECTOR_SIZE (VECTOR_SIZE),
    .L_RAM_SIZE  (L_RAM_SIZE)
  ) u_abuf (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (abuf_we),
    .waddr (idx_q[L_RAM_SIZE-1:0]),
    .wdata (s_tdata),
    .re    (abuf_re),
    .raddr (idx_q[L_RAM_SIZE-1:0]),
    .rdata (pe_ain)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_d      = 1'b0;
    pe_we_d    = 1'b0;
    pe_valid_d = 1'b0;
    pe_addr_d  = pe_addr_q;
    pe_din_d   = pe_din_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
`ifdef PE_SEQ_TIMEOUT_EN
    wdog_d     = wdog_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          clr_d   = 1'b1;
`ifdef PE_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      CLR: begin
        idx_d   = '0;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        if (beat) begin
          pe_we_d   = 1'b1;
          pe_addr_d = idx_q[L_RAM_SIZE-1:0];
          pe_din_d  = s_tdata;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      LOAD_A: begin
        if (beat) begin
          if (idx_q == LAST) begin
            idx_d     = '0;
            pe_addr_d = '0;
            state_d   = PREP;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      PREP: begin
        pe_valid_d = 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: begin
`ifdef PE_SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // A result always reaches PREP first, so ISSUE trails pe_dvalid by two cycles.
        if (pe_dvalid) begin
          if (idx_q == LAST) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = pe_dout;
            state_d    = OUT;
          end else begin
            idx_d     = idx_inc;
            pe_addr_d = idx_inc[L_RAM_SIZE-1:0];
            state_d   = PREP;
          end
        end
`ifdef PE_SEQ_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          m_tvalid_d = 1'b1;
          m_tdata_d  = VECTOR_SIZE'(FP_ZERO);
          state_d    = OUT;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
`endif
      end
      OUT: begin
        if (m_tready) begin
          m_tvalid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    s_tready_d = (state_d == LOAD_B) || (state_d == LOAD_A);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      s_tready_q <= 1'b0;
      pe_we_q    <= 1'b0;
      pe_valid_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      pe_addr_q  <= '0;
      pe_din_q   <= '0;
      m_tdata_q  <= '0;
`ifdef PE_SEQ_TIMEOUT_EN
      wdog_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      s_tready_q <= s_tready_d;
      pe_we_q    <= pe_we_d;
      pe_valid_q <= pe_valid_d;
      m_tvalid_q <= m_tvalid_d;
      pe_addr_q  <= pe_addr_d;
      pe_din_q   <= pe_din_d;
      m_tdata_q  <= m_tdata_d;
`ifdef PE_SEQ_TIMEOUT_EN
      wdog_q     <= wdog_d;
      err_q      <= err_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign s_tready   = s_tready_q;
  assign pe_aresetn = aresetn & ~clr_q;
  assign pe_we      = pe_we_q;
  assign pe_addr    = pe_addr_q;
  assign pe_din     = pe_din_q;
  assign pe_valid   = pe_valid_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tdata    = m_tdata_q;
`ifdef PE_SEQ_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule
